// File: rtl/dual_port_ram_param.sv
// dual_port_ram_param: true dual-port RAM with post-reset clear, collision arbitration, optional output register (DPRAM_OUT_REG_EN)
module dual_port_ram_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int RD_MODE = 0,
  parameter int COLL_PRIO = 0,
  parameter int CNT_W = 8,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] data_in_a,
  output logic [DATA_W-1:0] data_out_a,
  output logic              valid_a,
  input  logic              en_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] data_in_b,
  output logic [DATA_W-1:0] data_out_b,
  output logic              valid_b,
  output logic              busy,
  output logic              coll,
  output logic [CNT_W-1:0]  coll_cnt
);
  localparam int DEPTH = 2**ADDR_W;
  typedef enum logic {CLEAR, READY} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_a_q, rd_a_d, rd_b_q, rd_b_d;
  logic vld_a_q, vld_a_d, vld_b_q, vld_b_d, coll_q, coll_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic acc_a, acc_b, hit, wr_a, wr_b;
  // access qualification, collision arbitration, clear sequencing and read data selection
  always_comb begin
    acc_a = !rst && state_q == READY && en_a;
    acc_b = !rst && state_q == READY && en_b;
    hit = acc_a && we_a && acc_b && we_b && addr_a == addr_b;
    wr_a = acc_a && we_a && !(hit && COLL_PRIO != 0);
    wr_b = acc_b && we_b && !(hit && COLL_PRIO == 0);
    state_d = (state_q == CLEAR && ptr_q == '1) ? READY : state_q;
    ptr_d = (state_q == CLEAR) ? ptr_q + ADDR_W'(1) : ptr_q;
    rd_a_d = acc_a ? ((we_a && RD_MODE != 0) ? data_in_a : mem_q[addr_a]) : rd_a_q;
    rd_b_d = acc_b ? ((we_b && RD_MODE != 0) ? data_in_b : mem_q[addr_b]) : rd_b_q;
    vld_a_d = acc_a;
    vld_b_d = acc_b;
    coll_d = hit;
    cnt_d = (hit && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  // control and read-stage registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      ptr_q <= '0;
      rd_a_q <= '0;
      rd_b_q <= '0;
      vld_a_q <= 1'b0;
      vld_b_q <= 1'b0;
      coll_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      rd_a_q <= rd_a_d;
      rd_b_q <= rd_b_d;
      vld_a_q <= vld_a_d;
      vld_b_q <= vld_b_d;
      coll_q <= coll_d;
      cnt_q <= cnt_d;
    end
  end
  // storage: clear writes INIT_VAL at the pointer, otherwise the arbitrated port writes
  always_ff @(posedge clk) begin
    if (!rst && state_q == CLEAR) mem_q[ptr_q] <= INIT_VAL;
    if (wr_a) mem_q[addr_a] <= data_in_a;
    if (wr_b) mem_q[addr_b] <= data_in_b;
  end
`ifdef DPRAM_OUT_REG_EN
  logic [DATA_W-1:0] out_a_q, out_b_q;
  logic ov_a_q, ov_b_q;
  // extra output stage delaying data and valid together
  always_ff @(posedge clk) begin
    if (rst) begin
      out_a_q <= '0;
      out_b_q <= '0;
      ov_a_q <= 1'b0;
      ov_b_q <= 1'b0;
    end else begin
      out_a_q <= rd_a_q;
      out_b_q <= rd_b_q;
      ov_a_q <= vld_a_q;
      ov_b_q <= vld_b_q;
    end
  end
  assign data_out_a = out_a_q;
  assign data_out_b = out_b_q;
  assign valid_a = ov_a_q;
  assign valid_b = ov_b_q;
`else
  assign data_out_a = rd_a_q;
  assign data_out_b = rd_b_q;
  assign valid_a = vld_a_q;
  assign valid_b = vld_b_q;
`endif
  assign busy = state_q == CLEAR;
  assign coll = coll_q;
  assign coll_cnt = cnt_q;
endmodule

// File: doc/dual_port_ram_param.md
Name: dual_port_ram_param

Overview:
Parametrised true dual-port synchronous RAM, the successor to the fixed 16x8 dual-port RAM. Adds configurable width and depth, per-port enables with read-valid strobes, and a selectable same-port read-during-write mode. Adds deterministic write-collision arbitration with a saturating collision counter, and a post-reset memory clear sequencer. Used as shared scratch storage between two independent masters on one clock domain.

Parameters:
DATA_W, 8, data width per word (>=1)
ADDR_W, 4, address width; depth = 2**ADDR_W
RD_MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (new data)
COLL_PRIO, 0, simultaneous same-address write winner: 0 = port A, 1 = port B
CNT_W, 8, collision counter width
INIT_VAL, 0, value written to every word during clear (DATA_W bits)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
en_a  in  1  port A access enable
we_a  in  1  port A write enable (qualified by en_a)
addr_a  in  ADDR_W  port A address
data_in_a  in  DATA_W  port A write data
data_out_a  out  DATA_W  port A read data
valid_a  out  1  data_out_a holds fresh data for the last port A access
en_b, we_b, addr_b, data_in_b, data_out_b, valid_b: same as port A, for port B
busy  out  1  clear sequence in progress; all accesses ignored
coll  out  1  one-cycle pulse: same-address write collision occurred
coll_cnt  out  CNT_W  saturating count of collisions since reset

Behaviour:
- Reset (rst=1 at a clk edge): data_out_a/b=0, valid_a/b=0, coll=0, coll_cnt=0, busy=1, clear pointer=0.
- Clear FSM states: CLEAR, READY. The FSM enters CLEAR on reset. Each cycle in CLEAR writes INIT_VAL at the pointer, then increments the pointer. After writing address 2**ADDR_W-1, the FSM enters READY and busy=0 on the next cycle. Clear takes exactly 2**ADDR_W cycles after rst deasserts.
- Reset asserted mid-clear or mid-operation: the clear restarts from address 0. Memory contents at that point are don't-care until the clear completes.
- While busy=1: en_a/en_b are ignored. No writes occur, valid stays 0, and the collision logic is inactive.
- Access (READY, en=1): read latency 1. At edge N the port samples addr. data_out is updated at edge N and valid=1 for that cycle. When en=0, valid=0 and data_out holds its last value.
- Writes happen at edge N with we=1. The port still returns read data with valid=1, selected by RD_MODE:
  - RD_MODE=0: data_out = memory contents before the write.
  - RD_MODE=1: data_out = data_in.
- Cross-port read/write, same address, same cycle: the reading port always gets the old data (read-first across ports).
- Both ports write the same address in the same cycle:
  - The COLL_PRIO port's data is stored.
  - coll=1 for one cycle after the edge, and coll_cnt increments.
  - coll_cnt saturates at 2**CNT_W-1.
  - Each port's data_out follows its own RD_MODE rule using its own data_in.
- Both ports write different addresses: both writes commit, with no collision.
- Both ports read the same address: both return the same data, with no collision.
- Address wrap: addresses are exactly ADDR_W bits, with no out-of-range case.

Optional Feature:
Macro DPRAM_OUT_REG_EN.
- Defined: adds an output register stage per port. Read latency becomes 2 and valid is delayed with the data. Reset clears both stages. coll timing is unchanged.
- Undefined: latency is 1 as above.

Test Plan:
1. Reset and clear (ADDR_W=4): rst high for 2 cycles, then low.
   - busy stays high for exactly 16 cycles.
   - Reading addresses 0..15 then returns INIT_VAL (0x00) with valid_a=1 one cycle after each en_a.
2. Port A write/read: A writes 0xAA, 0xBB, 0xCC to addresses 0, 1, 2, then reads them back.
   - data_out_a = 0xAA, 0xBB, 0xCC, with latency 1.
   - Port B reads address 1 and gets 0xBB.
3. Read-during-write: address 5 holds 0x11; A writes 0x22 to address 5 with en_a=1.
   - RD_MODE=0: data_out_a=0x11.
   - RD_MODE=1: data_out_a=0x22.
   - A subsequent read returns 0x22 in both modes.
4. Collision: A writes 0xDD and B writes 0xEE to address 3 in the same cycle, with COLL_PRIO=0.
   - coll pulses for 1 cycle, coll_cnt=1, and a read of address 3 returns 0xDD.
   - Repeat with COLL_PRIO=1: the read returns 0xEE.
5. Counter saturation: CNT_W=2, issue 5 collisions.
   - coll_cnt reads 1, 2, 3, 3, 3.
   - rst returns coll_cnt to 0.
6. Mid-clear reset and accesses during busy:
   - Assert rst at clear pointer 7; busy stays high for 16 more cycles.
   - A write issued while busy is dropped: address 0 still reads INIT_VAL after the clear.
   - With DPRAM_OUT_REG_EN defined, valid arrives 2 cycles after en.
